fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
Control sequencer for the FIR datapath (tap BRAM, data BRAM, MAC/accumulator). It owns ap_start/ap_done/ap_idle, zeroes the data BRAM at start, and accepts AXI-Stream input samples into a circular buffer. It generates the tap and data BRAM addresses for each Tape_Num-tap MAC pass, strobes the accumulator, and presents each result on the output stream with tlast/length checking. The AXI4-Lite register block feeds cfg_start and cfg_data_length; the datapath consumes the address and strobe outputs.

Parameters:
pADDR_WIDTH, 12, BRAM byte-address width
pDATA_WIDTH, 32, data width of cfg_data_length
Tape_Num, 11, number of taps = data-buffer depth in words

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  async active-low reset
cfg_start  in  1  one-cycle pulse: ap_start written with 1
cfg_data_length  in  pDATA_WIDTH  samples per run; sampled on accepted start
status_rd  in  1  one-cycle pulse: ap_ctrl read (clears ap_done)
ap_start  out  1  start-accepted flag
ap_done  out  1  sticky run-complete flag
ap_idle  out  1  engine idle
tlast_err  out  1  sticky: ss_tlast disagreed with length
ss_tvalid  in  1  input sample valid
ss_tlast  in  1  input last
ss_tready  out  1  input ready
sm_tready  in  1  output ready
sm_tvalid  out  1  output valid (y held by datapath)
sm_tlast  out  1  output last
tap_A  out  pADDR_WIDTH  tap BRAM byte address
data_A  out  pADDR_WIDTH  data BRAM byte address
data_WE  out  4  data BRAM byte write enables
data_clr  out  1  datapath drives data_Di=0 when high
acc_clr  out  1  zero accumulator
acc_en  out  1  accumulate tap_Do*data_Do

Behaviour:
- One clock domain: axis_clk. axis_rst_n is asynchronous and active-low: when it asserts (also mid-run), all state resets immediately. Reset values: ap_idle=1; every other output 0; state IDLE.
- States: IDLE, CLEAR, WAIT_IN, MAC, FLUSH, OUT, DONE.
- IDLE: on cfg_start -> ap_start=1 for exactly 1 cycle, ap_idle=0, ap_done=0, tlast_err=0, len<=cfg_data_length, cnt<=0, newest<=Tape_Num-1, -> CLEAR. cfg_start in any other state is ignored.
- CLEAR: Tape_Num cycles, i=0..Tape_Num-1: data_A=4*i, data_WE=4'hF, data_clr=1. If len==0 -> DONE, else -> WAIT_IN.
- WAIT_IN: ss_tready=1.
  - On handshake (cycle T), combinationally in the same cycle: data_WE=4'hF, data_A=4*wp, where wp=(newest+1) mod Tape_Num.
  - Registered: newest<=wp; acc_clr=1 for 1 cycle (T); cnt<=cnt+1; latch lastflag=ss_tlast OR (cnt+1==len); tlast_err|= ss_tlast XOR (cnt+1==len).
  - Then -> MAC.
  - ss_tready=0 in every state except WAIT_IN.
- MAC: cycles T+1..T+Tape_Num, k=0..Tape_Num-1:
  - tap_A=4*k.
  - data_A=4*((newest-k) mod Tape_Num), wrapping from index 0 to Tape_Num-1.
  - data_WE=0.
- Read pipeline: BRAM read 1 cycle + operand register 1 cycle. acc_en is the MAC-issue strobe delayed 2 cycles, high T+3..T+Tape_Num+2.
- FLUSH: 2 cycles, then -> OUT at T+Tape_Num+3.
- OUT: sm_tvalid=1, sm_tlast=lastflag. Both held stable until sm_tready. On handshake: sm_tvalid=0; lastflag -> DONE else -> WAIT_IN.
  - Minimum per-sample period: Tape_Num+4 cycles.
  - Backpressure stalls only the OUT state.
- DONE: ap_idle=1, ap_done=1 -> IDLE.
- ap_done is sticky until status_rd or an accepted cfg_start. If status_rd and cfg_start coincide, cfg_start semantics apply.
- Early ss_tlast (cnt<len): run ends after that sample, tlast_err=1.
- Count reaches len without ss_tlast: run ends, sm_tlast=1, tlast_err=1.
- tap_A, data_A hold their last value outside CLEAR/WAIT_IN/MAC; WE=0 there.
- Byte addresses = index*4 and stay below 4*Tape_Num. len compare is full pDATA_WIDTH, unsigned.

Test Plan:
- Reset mid-MAC (Tape_Num=11, sample 3, k=5) -> all outputs at reset values within the assert cycle, ap_idle=1; a later cfg_start runs normally.
- cfg_start, len=3 -> ap_start 1 cycle; 11 CLEAR writes to data_A 0x00..0x28 with data_WE=F, data_clr=1; then ss_tready=1.
- Sample accepted at cycle T (first sample) -> data_A=0x00 at T; tap_A 0x00..0x28 at T+1..T+11 with data_A 0x00,0x28,0x24..0x04; acc_en T+3..T+13; sm_tvalid at T+14.
- 12 samples, len=12, ss_tlast on sample 12 -> 12th write lands at data_A=0x00 (wrap); only output 12 has sm_tlast=1; ap_done=1, ap_idle=1, tlast_err=0; status_rd clears ap_done.
- sm_tready held low 20 cycles in OUT -> sm_tvalid/sm_tlast stable, ss_tready=0 throughout, no acc_en.
- len=5, ss_tlast on sample 3 -> output 3 has sm_tlast=1, tlast_err=1, DONE. len=2, no tlast -> output 2 sm_tlast=1, tlast_err=1. len=0 -> DONE right after CLEAR, no ss_tready.

Source files
------------

// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - input/output sample stream handshake bundle for fir_seq_ctrl
//
// Signals:
//   ss_tvalid/ss_tlast -> sequencer   input sample valid / last marker
//   ss_tready          <- sequencer   input sample accepted this cycle
//   sm_tvalid/sm_tlast <- sequencer   output result valid / last marker
//   sm_tready          -> sequencer   output sink ready
// Modports: slave = sequencer side, master = stream source/sink side.
interface fir_seq_ctrl_if;
  logic ss_tvalid;
  logic ss_tlast;
  logic ss_tready;
  logic sm_tvalid;
  logic sm_tlast;
  logic sm_tready;

  modport slave (
    input  ss_tvalid, ss_tlast, sm_tready,
    output ss_tready, sm_tvalid, sm_tlast
  );

  modport master (
    output ss_tvalid, ss_tlast, sm_tready,
    input  ss_tready, sm_tvalid, sm_tlast
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR control sequencer: ap handshake, buffer clear, MAC addressing, output stream
//
// Ports:
//   axis_clk, axis_rst_n      clock, asynchronous active-low reset
//   cfg_start, cfg_data_length start pulse and samples-per-run from the register block
//   status_rd                 ap_ctrl read pulse, clears ap_done
//   ap_start/ap_done/ap_idle  engine status flags; tlast_err sticky length/tlast disagreement
//   axis                      input (ss_*) and output (sm_*) stream handshakes
//   tap_A, data_A, data_WE    tap/data BRAM byte addresses and data write enables
//   data_clr                  datapath writes zero into the data BRAM
//   acc_clr, acc_en           accumulator clear and accumulate strobes
module fir_seq_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [pDATA_WIDTH-1:0] cfg_data_length,
  input  logic                   status_rd,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   tlast_err,
  fir_seq_ctrl_if.slave          axis,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [3:0]             data_WE,
  output logic                   data_clr,
  output logic                   acc_clr,
  output logic                   acc_en
);

  localparam int CW = $clog2(Tape_Num + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(Tape_Num - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_FLUSH, S_OUT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          k_q, k_d;
  logic [CW-1:0]          newest_q, newest_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic [pDATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic                   idle_q, idle_d;
  logic                   err_q, err_d;
  logic [pADDR_WIDTH-1:0] tap_a_q, data_a_q;
  logic [1:0]             issue_q;

  logic [CW-1:0]          wp;
  logic [CW-1:0]          rd_idx;
  logic [pDATA_WIDTH-1:0] cnt_inc;
  logic                   cnt_hit;

  function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [CW-1:0] idx);
    return pADDR_WIDTH'(idx) << 2;
  endfunction

  // Circular buffer: the write slot follows the newest sample, the MAC walks
  // backwards from the newest sample so tap k meets sample n-k.
  assign wp      = (newest_q == LAST_IDX) ? '0 : newest_q + ONE;
  assign rd_idx  = (k_q <= newest_q) ? newest_q - k_q
                                     : newest_q + (LAST_IDX - k_q) + ONE;
  assign cnt_inc = cnt_q + pDATA_WIDTH'(1);
  assign cnt_hit = (cnt_inc == len_q);

  assign ap_start  = start_q;
  assign ap_done   = done_q;
  assign ap_idle   = idle_q;
  assign tlast_err = err_q;
  // MAC issue delayed by BRAM read + operand register stages.
  assign acc_en    = issue_q[1];

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    newest_d = newest_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    start_d  = 1'b0;
    done_d   = done_q;
    idle_d   = idle_q;
    err_d    = err_q;
    axis.ss_tready = 1'b0;
    axis.sm_tvalid = 1'b0;
    axis.sm_tlast  = 1'b0;
    tap_A    = tap_a_q;
    data_A   = data_a_q;
    data_WE  = 4'h0;
    data_clr = 1'b0;
    acc_clr  = 1'b0;

    if (status_rd) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          start_d  = 1'b1;
          idle_d   = 1'b0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          len_d    = cfg_data_length;
          cnt_d    = '0;
          newest_d = LAST_IDX;
          k_d      = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        data_A   = byte_addr(k_q);
        data_WE  = 4'hF;
        data_clr = 1'b1;
        if (k_q == LAST_IDX) begin
          k_d     = '0;
          state_d = (len_q == '0) ? S_DONE : S_WAIT_IN;
        end else begin
          k_d = k_q + ONE;
        end
      end
      S_WAIT_IN: begin
        axis.ss_tready = 1'b1;
        if (axis.ss_tvalid) begin
          data_WE  = 4'hF;
          data_A   = byte_addr(wp);
          acc_clr  = 1'b1;
          newest_d = wp;
          cnt_d    = cnt_inc;
          // A run ends on whichever comes first: tlast or the length count.
          last_d   = axis.ss_tlast | cnt_hit;
          err_d    = err_q | (axis.ss_tlast ^ cnt_hit);
          k_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        tap_A  = byte_addr(k_q);
        data_A = byte_addr(rd_idx);
        if (k_q == LAST_IDX) begin
          k_d     = '0;
          state_d = S_FLUSH;
        end else begin
          k_d = k_q + ONE;
        end
      end
      S_FLUSH: begin
        if (k_q == ONE) begin
          k_d     = '0;
          state_d = S_OUT;
        end else begin
          k_d = k_q + ONE;
        end
      end
      S_OUT: begin
        axis.sm_tvalid = 1'b1;
        axis.sm_tlast  = last_q;
        if (axis.sm_tready) state_d = last_q ? S_DONE : S_WAIT_IN;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flags become visible in the DONE cycle itself; a coincident status_rd loses.
    if (state_d == S_DONE && state_q != S_DONE) begin
      done_d = 1'b1;
      idle_d = 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      newest_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
      err_q    <= 1'b0;
      tap_a_q  <= '0;
      data_a_q <= '0;
      issue_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      newest_q <= newest_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      start_q  <= start_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      tap_a_q  <= tap_A;
      data_a_q <= data_A;
      issue_q  <= {issue_q[0], state_q == S_MAC};
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl
module tb_fir_seq_ctrl;
  localparam int TAPS = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_data_length = '0;
  logic        status_rd = 1'b0;
  logic        ap_start, ap_done, ap_idle, tlast_err;
  logic [11:0] tap_A, data_A;
  logic [3:0]  data_WE;
  logic        data_clr, acc_clr, acc_en;

  int n_total = 0;
  int n_pass  = 0;
  int newest_m = TAPS - 1;

  always #5 clk = ~clk;

  fir_seq_ctrl_if bus();

  fir_seq_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TAPS)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_data_length(cfg_data_length), .status_rd(status_rd),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .tlast_err(tlast_err),
    .axis(bus), .tap_A(tap_A), .data_A(data_A), .data_WE(data_WE),
    .data_clr(data_clr), .acc_clr(acc_clr), .acc_en(acc_en)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_idle"},    ap_idle, 1);
    chk({pfx, "_start"},   ap_start, 0);
    chk({pfx, "_done"},    ap_done, 0);
    chk({pfx, "_err"},     tlast_err, 0);
    chk({pfx, "_sstr"},    bus.ss_tready, 0);
    chk({pfx, "_smtv"},    bus.sm_tvalid, 0);
    chk({pfx, "_smtl"},    bus.sm_tlast, 0);
    chk({pfx, "_tapA"},    tap_A, 0);
    chk({pfx, "_dataA"},   data_A, 0);
    chk({pfx, "_we"},      data_WE, 0);
    chk({pfx, "_clr"},     data_clr, 0);
    chk({pfx, "_accclr"},  acc_clr, 0);
    chk({pfx, "_accen"},   acc_en, 0);
  endtask

  task automatic start_run(input int len);
    chk("pre_start_idle", ap_idle, 1);
    cfg_start = 1'b1;
    cfg_data_length = len;
    cyc();
    cfg_start = 1'b0;
    chk("start_ap_idle", ap_idle, 0);
    chk("start_ap_done", ap_done, 0);
    chk("start_err", tlast_err, 0);
    for (int i = 0; i < TAPS; i++) begin
      chk("clr_ap_start", ap_start, (i == 0));
      chk("clr_addr", data_A, 4 * i);
      chk("clr_we", data_WE, 4'hF);
      chk("clr_dclr", data_clr, 1);
      chk("clr_sstr", bus.ss_tready, 0);
      cyc();
    end
    newest_m = TAPS - 1;
  endtask

  task automatic do_sample(input bit tl, input bit exp_last, input int stall);
    int wp;
    wp = (newest_m + 1) % TAPS;
    chk("wait_sstr", bus.ss_tready, 1);
    chk("wait_smtv", bus.sm_tvalid, 0);
    bus.ss_tvalid = 1'b1;
    bus.ss_tlast  = tl;
    #1;
    chk("wr_addr", data_A, 4 * wp);
    chk("wr_we", data_WE, 4'hF);
    chk("wr_accclr", acc_clr, 1);
    cyc();
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
    newest_m = wp;
    for (int j = 1; j <= TAPS + 3; j++) begin
      if (j > 1) cyc();
      chk("acc_en", acc_en, (j >= 3 && j <= TAPS + 2));
      chk("busy_sstr", bus.ss_tready, 0);
      chk("busy_accclr", acc_clr, 0);
      chk("busy_we", data_WE, 0);
      chk("smtv", bus.sm_tvalid, (j == TAPS + 3));
      if (j <= TAPS) begin
        chk("mac_tapA", tap_A, 4 * (j - 1));
        chk("mac_dataA", data_A, 4 * ((wp - (j - 1) + TAPS) % TAPS));
      end else begin
        chk("hold_tapA", tap_A, 4 * (TAPS - 1));
        chk("hold_dataA", data_A, 4 * ((wp + 1) % TAPS));
      end
    end
    chk("out_last", bus.sm_tlast, exp_last);
    for (int s = 0; s < stall; s++) begin
      cfg_start = (s == 0);
      chk("stall_smtv", bus.sm_tvalid, 1);
      chk("stall_smtl", bus.sm_tlast, exp_last);
      chk("stall_sstr", bus.ss_tready, 0);
      chk("stall_accen", acc_en, 0);
      chk("stall_apstart", ap_start, 0);
      chk("stall_idle", ap_idle, 0);
      cyc();
    end
    cfg_start = 1'b0;
    bus.sm_tready = 1'b1;
    #1;
    chk("hs_smtv", bus.sm_tvalid, 1);
    chk("hs_smtl", bus.sm_tlast, exp_last);
    cyc();
    bus.sm_tready = 1'b0;
  endtask

  task automatic finish_run(input bit exp_err);
    chk("done_ap_done", ap_done, 1);
    chk("done_ap_idle", ap_idle, 1);
    chk("done_err", tlast_err, exp_err);
    chk("done_sstr", bus.ss_tready, 0);
    chk("done_smtv", bus.sm_tvalid, 0);
    cyc();
    chk("idle_done_sticky", ap_done, 1);
    chk("idle_ap_idle", ap_idle, 1);
    chk("idle_sstr", bus.ss_tready, 0);
  endtask

  task automatic clear_done();
    status_rd = 1'b1;
    cyc();
    status_rd = 1'b0;
    chk("rd_clears_done", ap_done, 0);
    chk("rd_keeps_idle", ap_idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
    bus.sm_tready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_state("rst");
    rst_n = 1'b1;
    cyc();
    chk_reset_state("post_rst");

    // len=3, tlast on sample 3, 20-cycle output stall with an ignored start pulse
    start_run(3);
    do_sample(1'b0, 1'b0, 0);
    do_sample(1'b0, 1'b0, 20);
    do_sample(1'b1, 1'b1, 0);
    finish_run(1'b0);
    clear_done();

    // len=12: buffer wraps on sample 12
    start_run(12);
    for (int i = 0; i < 12; i++) do_sample(i == 11, i == 11, 0);
    finish_run(1'b0);
    clear_done();

    // len=5, early tlast on sample 3; ap_done left set for next start to clear
    start_run(5);
    do_sample(1'b0, 1'b0, 0);
    do_sample(1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b1, 0);
    finish_run(1'b1);

    // len=2, no tlast: count ends the run
    start_run(2);
    do_sample(1'b0, 1'b0, 0);
    do_sample(1'b0, 1'b1, 0);
    finish_run(1'b1);
    clear_done();

    // len=0: straight to DONE after clearing
    start_run(0);
    finish_run(1'b0);
    clear_done();

    // reset in the middle of the MAC pass of sample 3 at k=5
    start_run(5);
    do_sample(1'b0, 1'b0, 0);
    do_sample(1'b0, 1'b0, 0);
    bus.ss_tvalid = 1'b1;
    cyc();
    bus.ss_tvalid = 1'b0;
    repeat (5) cyc();
    chk("premid_tapA", tap_A, 4 * 5);
    chk("premid_accen", acc_en, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    cyc();
    rst_n = 1'b1;
    cyc();
    start_run(1);
    do_sample(1'b1, 1'b1, 0);
    finish_run(1'b0);
    clear_done();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
